// File: rtl/vrf_pkg.sv
//------------------------------------------------------------------------------
// vrf_pkg
// Shared vector-register-file types and constants for the AGU front end.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package vrf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } agu_arb_state_t;

    localparam logic [1:0] SEW8  = 2'd0;
    localparam logic [1:0] SEW16 = 2'd1;
    localparam logic [1:0] SEW32 = 2'd2;
    localparam logic [1:0] SEW64 = 2'd3;

    localparam int DEF_VLEN       = 16384;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int BEATS_PER_REG  = DEF_VLEN / DEF_DATA_WIDTH;

    // Registers in a whole-register group for a given SEW encoding.
    function automatic logic [3:0] sew_group_regs(input logic [1:0] sew);
        case (sew)
            SEW8:    return 4'd1;
            SEW16:   return 4'd2;
            SEW32:   return 4'd4;
            SEW64:   return 4'd8;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb_pick.sv
//------------------------------------------------------------------------------
// rr_arb_pick
// Combinational round-robin pick: first asserted request after ptr, wrapping.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arb_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] w_cand [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
        assign w_cand[k] = IDX_W'((32'(ptr) + 32'(k) + 32'd1) % 32'(NUM_REQ));
    end

    // Walk candidates farthest-first so the nearest valid one is assigned last.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[w_cand[k]]) begin
                onehot            = '0;
                onehot[w_cand[k]] = 1'b1;
                idx               = w_cand[k];
                any               = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/agu_req_arbiter.sv
//------------------------------------------------------------------------------
// agu_req_arbiter
// Round-robin sharing of one address generator with config latch and watchdog.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module agu_req_arbiter
    import vrf_pkg::*;
#(
    parameter int NUM_REQ       = 3,
    parameter int VLEN          = DEF_VLEN,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH    = 5,
    parameter int OFF_WIDTH     = $clog2(VLEN / DATA_WIDTH),
    parameter int TIMEOUT_SLACK = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*2-1:0]            req_sew,
    input  logic [NUM_REQ*OFF_WIDTH-1:0]    req_max_off,
    input  logic [NUM_REQ*3-1:0]            req_max_reg,
    input  logic [NUM_REQ-1:0]              req_whole_reg,
    input  logic [NUM_REQ-1:0]              req_widen,
    output logic                            agu_en,
    output logic [ADDR_WIDTH-1:0]           agu_addr,
    output logic [1:0]                      agu_sew,
    output logic [OFF_WIDTH-1:0]            agu_max_off,
    output logic [2:0]                      agu_max_reg,
    output logic                            agu_whole_reg,
    output logic                            agu_widen,
    output logic [OFF_WIDTH-1:0]            agu_off,
    input  logic                            agu_idle,
    input  logic                            agu_addr_end,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy,
    output logic [NUM_REQ-1:0]              done,
    output logic                            err
);

    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int EXP_W  = OFF_WIDTH + 5;
    localparam int OFFS_W = OFF_WIDTH + 1;
    localparam int CNT_W  = EXP_W + 1;

    agu_arb_state_t r_state, w_state_nxt;

    logic [ID_W-1:0]       r_ptr;
    logic [ID_W-1:0]       r_grant;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_sew;
    logic [OFF_WIDTH-1:0]  r_max_off;
    logic [2:0]            r_max_reg;
    logic                  r_whole;
    logic                  r_widen;
    logic [EXP_W-1:0]      r_expected;
    logic [CNT_W-1:0]      r_beat_cnt;
    logic [NUM_REQ-1:0]    r_done;
    logic                  r_err;

    logic [NUM_REQ-1:0]    w_onehot;
    logic [ID_W-1:0]       w_idx;
    logic                  w_any;

    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [1:0]            w_sel_sew;
    logic [OFF_WIDTH-1:0]  w_sel_max_off;
    logic [2:0]            w_sel_max_reg;
    logic                  w_sel_whole;
    logic                  w_sel_widen;

    logic [3:0]            w_regs;
    logic [OFFS_W-1:0]     w_offs;
    logic [EXP_W-1:0]      w_expected;
    logic [CNT_W-1:0]      w_beat_now;
    logic [CNT_W-1:0]      w_limit;
    logic                  w_timeout;

    logic                  w_grant_fire;
    logic                  w_sweep_end;
    logic                  w_sweep_to;

    rr_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_pick (
        .req    (req_valid),
        .ptr    (r_ptr),
        .onehot (w_onehot),
        .idx    (w_idx),
        .any    (w_any)
    );

    always_comb begin
        w_sel_addr    = '0;
        w_sel_sew     = '0;
        w_sel_max_off = '0;
        w_sel_max_reg = '0;
        w_sel_whole   = 1'b0;
        w_sel_widen   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_onehot[i]) begin
                w_sel_addr    = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_sew     = req_sew[i*2 +: 2];
                w_sel_max_off = req_max_off[i*OFF_WIDTH +: OFF_WIDTH];
                w_sel_max_reg = req_max_reg[i*3 +: 3];
                w_sel_whole   = req_whole_reg[i];
                w_sel_widen   = req_widen[i];
            end
        end
    end

    // Beat budget of the sweep being granted, captured alongside its config.
    always_comb begin
        w_regs     = w_sel_whole ? sew_group_regs(w_sel_sew)
                                 : {1'b0, w_sel_max_reg} + 4'd1;
        w_offs     = w_sel_whole ? OFFS_W'(VLEN / DATA_WIDTH)
                                 : {1'b0, w_sel_max_off} + OFFS_W'(1);
        w_expected = (EXP_W'(w_regs) * EXP_W'(w_offs)) << w_sel_widen;
    end

    // w_beat_now counts the current BUSY cycle, so the watchdog fires on the
    // (expected + slack)-th BUSY cycle without an end-of-sweep.
    assign w_beat_now = r_beat_cnt + CNT_W'(1);
    assign w_limit    = {1'b0, r_expected} + CNT_W'(TIMEOUT_SLACK);
    assign w_timeout  = (w_beat_now == w_limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_fire = 1'b0;
        w_sweep_end  = 1'b0;
        w_sweep_to   = 1'b0;
        req_ready    = '0;
        agu_en       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any && agu_idle && rst_n) begin
                    req_ready    = w_onehot;
                    w_grant_fire = 1'b1;
                    w_state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                agu_en      = 1'b1;
                w_state_nxt = BUSY;
            end
            BUSY: begin
                if (agu_addr_end) begin
                    w_sweep_end = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_timeout) begin
                    w_sweep_to  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= ID_W'(NUM_REQ - 1);
            r_grant    <= '0;
            r_addr     <= '0;
            r_sew      <= '0;
            r_max_off  <= '0;
            r_max_reg  <= '0;
            r_whole    <= 1'b0;
            r_widen    <= 1'b0;
            r_expected <= '0;
            r_beat_cnt <= '0;
            r_done     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_done <= '0;
            r_err  <= 1'b0;
            if (w_grant_fire) begin
                r_grant    <= w_idx;
                r_addr     <= w_sel_addr;
                r_sew      <= w_sel_sew;
                r_max_off  <= w_sel_max_off;
                r_max_reg  <= w_sel_max_reg;
                r_whole    <= w_sel_whole;
                r_widen    <= w_sel_widen;
                r_expected <= w_expected;
            end
            if (r_state == ISSUE) begin
                r_beat_cnt <= '0;
            end else if (r_state == BUSY) begin
                r_beat_cnt <= w_beat_now;
            end
            if (w_sweep_end) begin
                r_done <= NUM_REQ'(1) << r_grant;
                r_ptr  <= r_grant;
            end
            if (w_sweep_to) begin
                r_err <= 1'b1;
                r_ptr <= r_grant;
            end
        end
    end

    assign agu_addr      = r_addr;
    assign agu_sew       = r_sew;
    assign agu_max_off   = r_max_off;
    assign agu_max_reg   = r_max_reg;
    assign agu_whole_reg = r_whole;
    assign agu_widen     = r_widen;
    assign agu_off       = '0;
    assign grant_id      = r_grant;
    assign busy          = (r_state != IDLE);
    assign done          = r_done;
    assign err           = r_err;

endmodule

`default_nettype wire

// File: tb/tb_agu_req_arbiter.sv
//------------------------------------------------------------------------------
// tb_agu_req_arbiter
// Randomized and directed sweeps against a transaction-level arbiter model.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_agu_req_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 5;
    localparam int OFF_W   = 8;
    localparam int SLACK   = 4;
    localparam int BPR     = 256;

    logic                       clk;
    logic                       rst_n;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*ADDR_W-1:0]  req_addr;
    logic [NUM_REQ*2-1:0]       req_sew;
    logic [NUM_REQ*OFF_W-1:0]   req_max_off;
    logic [NUM_REQ*3-1:0]       req_max_reg;
    logic [NUM_REQ-1:0]         req_whole_reg;
    logic [NUM_REQ-1:0]         req_widen;
    logic                       agu_en;
    logic [ADDR_W-1:0]          agu_addr;
    logic [1:0]                 agu_sew;
    logic [OFF_W-1:0]           agu_max_off;
    logic [2:0]                 agu_max_reg;
    logic                       agu_whole_reg;
    logic                       agu_widen;
    logic [OFF_W-1:0]           agu_off;
    logic                       agu_idle;
    logic                       agu_addr_end;
    logic [1:0]                 grant_id;
    logic                       busy;
    logic [NUM_REQ-1:0]         done;
    logic                       err;

    agu_req_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_sew       (req_sew),
        .req_max_off   (req_max_off),
        .req_max_reg   (req_max_reg),
        .req_whole_reg (req_whole_reg),
        .req_widen     (req_widen),
        .agu_en        (agu_en),
        .agu_addr      (agu_addr),
        .agu_sew       (agu_sew),
        .agu_max_off   (agu_max_off),
        .agu_max_reg   (agu_max_reg),
        .agu_whole_reg (agu_whole_reg),
        .agu_widen     (agu_widen),
        .agu_off       (agu_off),
        .agu_idle      (agu_idle),
        .agu_addr_end  (agu_addr_end),
        .grant_id      (grant_id),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Requester configs as plain integers
    int c_addr [NUM_REQ];
    int c_sew  [NUM_REQ];
    int c_moff [NUM_REQ];
    int c_mreg [NUM_REQ];
    int c_whole[NUM_REQ];
    int c_widen[NUM_REQ];

    // Model state
    int m_ptr     = NUM_REQ - 1;
    int pend_done = 0;
    int pend_err  = 0;

    task automatic rand_cfg();
        for (int i = 0; i < NUM_REQ; i++) begin
            c_addr[i]  = $urandom_range(0, 31);
            c_sew[i]   = $urandom_range(0, 3);
            c_moff[i]  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
            c_mreg[i]  = $urandom_range(0, 7);
            c_whole[i] = ($urandom_range(0, 7) == 0) ? 1 : 0;
            c_widen[i] = $urandom_range(0, 1);
        end
    endtask

    task automatic apply_cfg();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(c_addr[i]);
            req_sew[i*2 +: 2]            = 2'(c_sew[i]);
            req_max_off[i*OFF_W +: OFF_W] = OFF_W'(c_moff[i]);
            req_max_reg[i*3 +: 3]        = 3'(c_mreg[i]);
            req_whole_reg[i]             = c_whole[i][0];
            req_widen[i]                 = c_widen[i][0];
        end
    endtask

    function automatic int pick(input int v);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic int exp_beats(input int i);
        int regs;
        int offs;
        regs = (c_whole[i] != 0) ? (1 << c_sew[i]) : c_mreg[i] + 1;
        offs = (c_whole[i] != 0) ? BPR : c_moff[i] + 1;
        return (regs * offs) << c_widen[i];
    endfunction

    task automatic check_pending();
        check_eq("done_pulse", done, pend_done);
        check_eq("err_pulse", err, pend_err);
        pend_done = 0;
        pend_err  = 0;
    endtask

    // Entered #1 after a rising edge with the DUT in IDLE; returns at the same
    // point of the IDLE cycle that follows the sweep. end_beat = 0 never ends.
    task automatic sweep(input int v, input int end_beat, input int idle_wait, input bit hold);
        int w, lim, sa, ss, so, sr, sw, sd;
        bit ended;
        req_valid = NUM_REQ'(v);
        apply_cfg();
        for (int k = 0; k < idle_wait; k++) begin
            agu_idle = 1'b0;
            @(negedge clk);
            check_eq("ready_while_agu_busy", req_ready, 0);
            check_eq("busy_idle", busy, 0);
            check_pending();
            @(posedge clk); #1;
        end
        agu_idle = 1'b1;
        w   = pick(v);
        lim = exp_beats(w) + SLACK;
        sa = c_addr[w]; ss = c_sew[w]; so = c_moff[w];
        sr = c_mreg[w]; sw = c_whole[w]; sd = c_widen[w];
        @(negedge clk);
        check_eq("ready_onehot", req_ready, 1 << w);
        check_eq("busy_idle", busy, 0);
        check_pending();
        @(posedge clk); #1;
        if (!hold) req_valid = '0;
        rand_cfg();
        apply_cfg();
        agu_idle     = 1'($urandom_range(0, 1));
        agu_addr_end = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_eq("issue_en", agu_en, 1);
        check_eq("issue_addr", agu_addr, sa);
        check_eq("issue_sew", agu_sew, ss);
        check_eq("issue_max_off", agu_max_off, so);
        check_eq("issue_max_reg", agu_max_reg, sr);
        check_eq("issue_whole", agu_whole_reg, sw);
        check_eq("issue_widen", agu_widen, sd);
        check_eq("issue_off", agu_off, 0);
        check_eq("issue_grant_id", grant_id, w);
        check_eq("issue_busy", busy, 1);
        check_eq("issue_ready", req_ready, 0);
        check_eq("issue_done", done, 0);
        @(posedge clk); #1;
        ended = 1'b0;
        for (int n = 1; n <= lim; n++) begin
            agu_addr_end = (n == end_beat);
            @(negedge clk);
            check_eq("busy_busy", busy, 1);
            check_eq("busy_en", agu_en, 0);
            check_eq("busy_done", done, 0);
            check_eq("busy_err", err, 0);
            check_eq("busy_ready", req_ready, 0);
            check_eq("busy_addr_hold", agu_addr, sa);
            @(posedge clk); #1;
            if (n == end_beat) begin
                ended = 1'b1;
                break;
            end
        end
        agu_addr_end = 1'($urandom_range(0, 1));
        pend_done = ended ? (1 << w) : 0;
        pend_err  = ended ? 0 : 1;
        m_ptr     = w;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int v, w, e, eb;
        rst_n        = 1'b0;
        req_valid    = '0;
        agu_idle     = 1'b1;
        agu_addr_end = 1'b0;
        rand_cfg();
        apply_cfg();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_en", agu_en, 0);
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_grant_id", grant_id, 0);
        check_eq("rst_addr", agu_addr, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic sweep: 2 regs x 4 beats, end on the 8th BUSY beat
        rand_cfg();
        c_addr[0] = 8; c_mreg[0] = 1; c_moff[0] = 3; c_whole[0] = 0; c_widen[0] = 0;
        sweep(3'b001, 8, 0, 1'b0);

        // All three held valid, short sweeps
        for (int k = 0; k < 6; k++) begin
            rand_cfg();
            sweep(3'b111, 2, 0, 1'b1);
        end

        // Widening: expected 4, end on beat 4
        rand_cfg();
        c_whole[1] = 0; c_widen[1] = 1; c_mreg[1] = 0; c_moff[1] = 1;
        sweep(3'b010, 4, 0, 1'b0);
        // Whole register SEW32: expected 1024
        rand_cfg();
        c_whole[2] = 1; c_sew[2] = 2; c_widen[2] = 0;
        sweep(3'b100, 1024, 0, 1'b0);
        // Widening timeout at beat 8
        rand_cfg();
        c_whole[0] = 0; c_widen[0] = 1; c_mreg[0] = 0; c_moff[0] = 1;
        sweep(3'b001, 0, 0, 1'b0);
        // Expected 1, no end: timeout on 5th BUSY cycle
        rand_cfg();
        c_whole[0] = 0; c_widen[0] = 0; c_mreg[0] = 0; c_moff[0] = 0;
        sweep(3'b001, 0, 0, 1'b0);
        // Same-cycle end and timeout: done wins
        rand_cfg();
        c_whole[1] = 0; c_widen[1] = 0; c_mreg[1] = 0; c_moff[1] = 0;
        sweep(3'b010, 5, 0, 1'b0);
        // AGU not idle for a few cycles
        rand_cfg();
        sweep(3'b100, 3, 3, 1'b0);

        // Randomized sweeps
        for (int t = 0; t < 30; t++) begin
            rand_cfg();
            v = $urandom_range(1, 7);
            w = pick(v);
            e = exp_beats(w);
            if (e + SLACK <= 40 && $urandom_range(0, 2) == 0) eb = 0;
            else eb = $urandom_range(1, (e + SLACK < 40) ? e + SLACK : 40);
            sweep(v, eb, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a sweep
        req_valid = 3'b100;
        agu_idle  = 1'b1;
        rand_cfg();
        apply_cfg();
        @(negedge clk);
        check_pending();
        @(posedge clk); #1;
        agu_addr_end = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n     = 1'b0;
        req_valid = 3'b011;
        #1;
        check_eq("async_rst_busy", busy, 0);
        check_eq("async_rst_en", agu_en, 0);
        check_eq("async_rst_ready", req_ready, 0);
        check_eq("async_rst_done", done, 0);
        check_eq("async_rst_err", err, 0);
        check_eq("async_rst_grant_id", grant_id, 0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        m_ptr     = NUM_REQ - 1;
        pend_done = 0;
        pend_err  = 0;
        rand_cfg();
        sweep(3'b011, 2, 0, 1'b0);

        req_valid = '0;
        @(negedge clk);
        check_pending();
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
